rob_wb_arbiter: RTL and testbench

//  Shares the ROB's two write-back ports (O, T) among NUM_REQ execution units (ALUs, LSU, BRU).

---
 rtl/rob_wb_arbiter_pkg.sv | 23 ++
 rtl/rob_wb_arbiter_if.sv | 61 ++++++
 rtl/rob_wb_arbiter_rr_pick2.sv | 43 ++++
 rtl/rob_wb_arbiter.sv | 168 ++++++++++++++++
 tb/tb_rob_wb_arbiter.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/rob_wb_arbiter_pkg.sv
// Shared definitions for the ROB write-back arbiter: default widths,
// idle ("free") fill values driven on unused write ports, and the
// enable encoding used on the ROB write enables.
// Optional feature macro: WB_PERF_CNT_EN (per-slot conflict counters).
package rob_wb_arbiter_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_TAG_W   = 5;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_NAME_W  = 5;
    localparam int PERF_W      = 16;

    // Idle write ports repeat these bits across the whole field.
    localparam logic TAG_FREE_BIT  = 1'b0;
    localparam logic DATA_FREE_BIT = 1'b0;
    localparam logic NAME_FREE_BIT = 1'b0;

    typedef enum logic {
        WB_DISABLE = 1'b0,
        WB_ENABLE  = 1'b1
    } wbEnable_e;

endpackage

// File: rtl/rob_wb_arbiter_if.sv
// Bundle of the unit result buses and the two ROB write ports.
// The execution-unit/ROB side uses the master modport, the arbiter
// uses the slave modport. WB_PERF_CNT_EN adds the perf_conflict output.
interface rob_wb_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 32,
    parameter int NAME_W  = 5
);
    logic                    clr;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*NAME_W-1:0] req_name;

    logic              en_wrt_o;
    logic [TAG_W-1:0]  wrt_tag_o;
    logic [DATA_W-1:0] wrt_data_o;
    logic [NAME_W-1:0] wrt_name_o;

    logic              en_wrt_t;
    logic [TAG_W-1:0]  wrt_tag_t;
    logic [DATA_W-1:0] wrt_data_t;
    logic [NAME_W-1:0] wrt_name_t;

`ifdef WB_PERF_CNT_EN
    logic [NUM_REQ*16-1:0] perf_conflict;

    modport master (
        output clr, req_valid, req_tag, req_data, req_name,
        input  req_ready,
        input  en_wrt_o, wrt_tag_o, wrt_data_o, wrt_name_o,
        input  en_wrt_t, wrt_tag_t, wrt_data_t, wrt_name_t,
        input  perf_conflict
    );

    modport slave (
        input  clr, req_valid, req_tag, req_data, req_name,
        output req_ready,
        output en_wrt_o, wrt_tag_o, wrt_data_o, wrt_name_o,
        output en_wrt_t, wrt_tag_t, wrt_data_t, wrt_name_t,
        output perf_conflict
    );
`else
    modport master (
        output clr, req_valid, req_tag, req_data, req_name,
        input  req_ready,
        input  en_wrt_o, wrt_tag_o, wrt_data_o, wrt_name_o,
        input  en_wrt_t, wrt_tag_t, wrt_data_t, wrt_name_t
    );

    modport slave (
        input  clr, req_valid, req_tag, req_data, req_name,
        output req_ready,
        output en_wrt_o, wrt_tag_o, wrt_data_o, wrt_name_o,
        output en_wrt_t, wrt_tag_t, wrt_data_t, wrt_name_t
    );
`endif

endinterface

// File: rtl/rob_wb_arbiter_rr_pick2.sv
// Round-robin picker that selects up to two pending slots per cycle.
// Scanning starts at rr_ptr and wraps; the first hit goes to port O,
// the second to port T. last_idx is the final winner so the caller can
// move the pointer just past it.
module rr_pick2 #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pend,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [NUM_REQ-1:0] gnt_t,
    output logic               any_o,
    output logic               any_t,
    output logic [PTR_W-1:0]   last_idx
);

    logic [PTR_W-1:0] scanIdx;

    // Wrap-around scan from the pointer, taking the first two pending slots.
    always_comb begin
        gnt_o    = '0;
        gnt_t    = '0;
        any_o    = 1'b0;
        any_t    = 1'b0;
        last_idx = '0;
        scanIdx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scanIdx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (pend[scanIdx] && !any_t) begin
                if (!any_o) begin
                    gnt_o[scanIdx] = 1'b1;
                    any_o          = 1'b1;
                end else begin
                    gnt_t[scanIdx] = 1'b1;
                    any_t          = 1'b1;
                end
                last_idx = scanIdx;
            end
        end
    end

endmodule

// File: rtl/rob_wb_arbiter.sv
// Shares the ROB's two write-back ports among NUM_REQ execution units.
// Each unit owns a one-entry holding slot; a round-robin picker drains up
// to two slots per cycle. A flush (clr) drops every held result.
// Optional feature macro: WB_PERF_CNT_EN adds 16-bit saturating counters
// of cycles each slot waited while pending.
module rob_wb_arbiter
    import rob_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NAME_W  = DEF_NAME_W
) (
    input logic clk,
    input logic rst,
    rob_wb_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [TAG_W-1:0]  TAG_FREE  = {TAG_W{TAG_FREE_BIT}};
    localparam logic [DATA_W-1:0] DATA_FREE = {DATA_W{DATA_FREE_BIT}};
    localparam logic [NAME_W-1:0] NAME_FREE = {NAME_W{NAME_FREE_BIT}};

    logic [NUM_REQ-1:0] pend;
    logic [TAG_W-1:0]   slotTag  [NUM_REQ];
    logic [DATA_W-1:0]  slotData [NUM_REQ];
    logic [NAME_W-1:0]  slotName [NUM_REQ];
    logic [PTR_W-1:0]   rrPtr;

    logic [NUM_REQ-1:0] pickO;
    logic [NUM_REQ-1:0] pickT;
    logic               anyO;
    logic               anyT;
    logic [PTR_W-1:0]   lastIdx;

    logic [NUM_REQ-1:0] grantO;
    logic [NUM_REQ-1:0] grantT;
    logic [NUM_REQ-1:0] grantAny;
    logic [NUM_REQ-1:0] ready;

    rr_pick2 #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) picker (
        .pend     (pend),
        .rr_ptr   (rrPtr),
        .gnt_o    (pickO),
        .gnt_t    (pickT),
        .any_o    (anyO),
        .any_t    (anyT),
        .last_idx (lastIdx)
    );

    // A flush masks every grant; ready lets a granted slot refill in the same cycle.
    always_comb begin
        grantO   = bus.clr ? '0 : pickO;
        grantT   = bus.clr ? '0 : pickT;
        grantAny = grantO | grantT;
        ready    = {NUM_REQ{~bus.clr}} & (~pend | grantAny);
    end

    assign bus.req_ready = ready;
    assign bus.en_wrt_o  = (anyO && !bus.clr) ? WB_ENABLE : WB_DISABLE;
    assign bus.en_wrt_t  = (anyT && !bus.clr) ? WB_ENABLE : WB_DISABLE;

    // One-hot write-port muxes; ports fall back to the free values when idle.
    always_comb begin
        bus.wrt_tag_o  = TAG_FREE;
        bus.wrt_data_o = DATA_FREE;
        bus.wrt_name_o = NAME_FREE;
        bus.wrt_tag_t  = TAG_FREE;
        bus.wrt_data_t = DATA_FREE;
        bus.wrt_name_t = NAME_FREE;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantO[i]) begin
                bus.wrt_tag_o  = slotTag[i];
                bus.wrt_data_o = slotData[i];
                bus.wrt_name_o = slotName[i];
            end
            if (grantT[i]) begin
                bus.wrt_tag_t  = slotTag[i];
                bus.wrt_data_t = slotData[i];
                bus.wrt_name_t = slotName[i];
            end
        end
    end

    // Holding slots: flush clears, handshake loads, otherwise a grant drains.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slotTag[i]  <= TAG_FREE;
                slotData[i] <= DATA_FREE;
                slotName[i] <= NAME_FREE;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.clr) begin
                    pend[i] <= 1'b0;
                end else if (bus.req_valid[i] && ready[i]) begin
                    pend[i]     <= 1'b1;
                    slotTag[i]  <= bus.req_tag[i*TAG_W +: TAG_W];
                    slotData[i] <= bus.req_data[i*DATA_W +: DATA_W];
                    slotName[i] <= bus.req_name[i*NAME_W +: NAME_W];
                end else if (grantAny[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    // Pointer moves just past the last winner so a losing slot is first next time.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rrPtr <= '0;
        end else if (anyO && !bus.clr) begin
            rrPtr <= (lastIdx == PTR_W'(NUM_REQ - 1)) ? '0 : lastIdx + PTR_W'(1);
        end
    end

`ifdef WB_PERF_CNT_EN
    logic [PERF_W-1:0] perfCnt [NUM_REQ];

    // Count cycles a slot sat pending without a grant; saturate at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                perfCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pend[i] && !grantAny[i] && !bus.clr && (perfCnt[i] != '1)) begin
                    perfCnt[i] <= perfCnt[i] + PERF_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
        assign bus.perf_conflict[g*PERF_W +: PERF_W] = perfCnt[g];
    end
`endif

`ifndef SYNTHESIS
    logic dupTag;

    // Two live slots carrying one tag would make the ROB write the same entry twice.
    always_comb begin
        dupTag = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = i + 1; j < NUM_REQ; j++) begin
                if (pend[i] && pend[j] && (slotTag[i] == slotTag[j])) begin
                    dupTag = 1'b1;
                end
            end
        end
    end

    // Flag duplicate pending tags while out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!dupTag);
        end
    end
`endif

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Directed bench for rob_wb_arbiter: reset, single result, round-robin
// fairness, back-to-back results from one unit, flush and (with
// WB_PERF_CNT_EN) the conflict counters. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_rob_wb_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 5;
    localparam int DATA_W  = 32;
    localparam int NAME_W  = 5;
    localparam logic [TAG_W-1:0] TAG_FREE_TB = 5'h00;

    logic clk;
    logic rst;

    rob_wb_arbiter_if #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W),
        .NAME_W  (NAME_W)
    ) bus ();

    rob_wb_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W),
        .NAME_W  (NAME_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checkCount = 0;
    int errorCount = 0;
    int seq [NUM_REQ];
    logic [NUM_REQ-1:0] fired;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [TAG_W-1:0] tagOf(input int unit, input int k);
        return TAG_W'((unit << 3) | (k & 7));
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic clrIn);
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i]                = valid[i];
            bus.req_tag[i*TAG_W +: TAG_W]   = tagOf(i, seq[i]);
            bus.req_data[i*DATA_W +: DATA_W] = 32'(32'hA500_0000 | (i << 16) | seq[i]);
            bus.req_name[i*NAME_W +: NAME_W] = NAME_W'(i * 4 + seq[i]);
        end
        bus.clr = clrIn;
    endtask

    task automatic stepCycle();
        fired = bus.req_valid & bus.req_ready;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (fired[i]) seq[i]++;
        end
    endtask

    task automatic doReset();
        for (int i = 0; i < NUM_REQ; i++) seq[i] = 0;
        rst = 1'b0;
        applyStimulus('0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int o;
        int k;
        for (int i = 0; i < NUM_REQ; i++) seq[i] = 0;
        fired = '0;

        // Reset held for two edges with every unit offering a result
        rst = 1'b0;
        applyStimulus('1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("t1_enO", 64'(bus.en_wrt_o), 64'(1'b0));
        checkOutput("t1_enT", 64'(bus.en_wrt_t), 64'(1'b0));
        checkOutput("t1_tagO", 64'(bus.wrt_tag_o), 64'(TAG_FREE_TB));
        checkOutput("t1_tagT", 64'(bus.wrt_tag_t), 64'(TAG_FREE_TB));
        rst = 1'b1;
        applyStimulus('0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("t1_noPend", 64'(bus.en_wrt_o), 64'(1'b0));
        checkOutput("t1_ready", 64'(bus.req_ready), 64'(4'hF));

        // Single result from unit 2
        doReset();
        applyStimulus('0, 1'b0);
        bus.req_valid[2] = 1'b1;
        bus.req_tag[2*TAG_W +: TAG_W]    = 5'h03;
        bus.req_data[2*DATA_W +: DATA_W] = 32'h0000_DEAD;
        bus.req_name[2*NAME_W +: NAME_W] = 5'h07;
        #1;
        checkOutput("t2_noCombPath", 64'(bus.en_wrt_o), 64'(1'b0));
        checkOutput("t2_ready2", 64'(bus.req_ready[2]), 64'(1'b1));
        stepCycle();
        applyStimulus('0, 1'b0);
        checkOutput("t2_enO", 64'(bus.en_wrt_o), 64'(1'b1));
        checkOutput("t2_tagO", 64'(bus.wrt_tag_o), 64'(5'h03));
        checkOutput("t2_dataO", 64'(bus.wrt_data_o), 64'(32'h0000_DEAD));
        checkOutput("t2_nameO", 64'(bus.wrt_name_o), 64'(5'h07));
        checkOutput("t2_enT", 64'(bus.en_wrt_t), 64'(1'b0));
        checkOutput("t2_tagT", 64'(bus.wrt_tag_t), 64'(TAG_FREE_TB));
        stepCycle();
        checkOutput("t2_drained", 64'(bus.en_wrt_o), 64'(1'b0));

        // Fairness: all four units saturate, grants alternate (0,1) and (2,3)
        doReset();
        applyStimulus('1, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            stepCycle();
            o = (c % 2 == 1) ? 0 : 2;
            k = (c % 2 == 1) ? (c - 1) / 2 : c / 2 - 1;
            checkOutput($sformatf("t3_enO_c%0d", c), 64'(bus.en_wrt_o), 64'(1'b1));
            checkOutput($sformatf("t3_enT_c%0d", c), 64'(bus.en_wrt_t), 64'(1'b1));
            checkOutput($sformatf("t3_tagO_c%0d", c), 64'(bus.wrt_tag_o), 64'(tagOf(o, k)));
            checkOutput($sformatf("t3_tagT_c%0d", c), 64'(bus.wrt_tag_t), 64'(tagOf(o + 1, k)));
            checkOutput($sformatf("t3_ready_c%0d", c), 64'(bus.req_ready),
                        64'((c % 2 == 1) ? 4'b0011 : 4'b1100));
            applyStimulus('1, 1'b0);
        end

        // Back-to-back: unit 1 offers five results in a row
        doReset();
        applyStimulus(4'b0010, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            stepCycle();
            checkOutput($sformatf("t4_enO_c%0d", c), 64'(bus.en_wrt_o), 64'(1'b1));
            checkOutput($sformatf("t4_tagO_c%0d", c), 64'(bus.wrt_tag_o), 64'(tagOf(1, c - 1)));
            checkOutput($sformatf("t4_enT_c%0d", c), 64'(bus.en_wrt_t), 64'(1'b0));
            checkOutput($sformatf("t4_ready1_c%0d", c), 64'(bus.req_ready[1]), 64'(1'b1));
            applyStimulus((c < 5) ? 4'b0010 : 4'b0000, 1'b0);
        end
        stepCycle();
        checkOutput("t4_drained", 64'(bus.en_wrt_o), 64'(1'b0));

        // Flush with three slots pending while unit 3 tries to hand over
        doReset();
        applyStimulus(4'b0111, 1'b0);
        stepCycle();
        checkOutput("t5_preEnO", 64'(bus.en_wrt_o), 64'(1'b1));
        checkOutput("t5_preTagO", 64'(bus.wrt_tag_o), 64'(tagOf(0, 0)));
        checkOutput("t5_preEnT", 64'(bus.en_wrt_t), 64'(1'b1));
        checkOutput("t5_preTagT", 64'(bus.wrt_tag_t), 64'(tagOf(1, 0)));
        applyStimulus(4'b1000, 1'b1);
        #1;
        checkOutput("t5_clrEnO", 64'(bus.en_wrt_o), 64'(1'b0));
        checkOutput("t5_clrEnT", 64'(bus.en_wrt_t), 64'(1'b0));
        checkOutput("t5_clrTagO", 64'(bus.wrt_tag_o), 64'(TAG_FREE_TB));
        checkOutput("t5_clrReady", 64'(bus.req_ready), 64'(4'b0000));
        stepCycle();
        applyStimulus('0, 1'b0);
        #1;
        checkOutput("t5_postEnO", 64'(bus.en_wrt_o), 64'(1'b0));
        checkOutput("t5_postEnT", 64'(bus.en_wrt_t), 64'(1'b0));
        checkOutput("t5_postReady", 64'(bus.req_ready), 64'(4'hF));

`ifdef WB_PERF_CNT_EN
        // Conflict counters after ten saturated cycles
        doReset();
        applyStimulus('1, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            stepCycle();
            applyStimulus((c < 10) ? 4'hF : 4'h0, 1'b0);
        end
        checkOutput("t6_perf0", 64'(bus.perf_conflict[0*16 +: 16]), 64'(16'd4));
        checkOutput("t6_perf1", 64'(bus.perf_conflict[1*16 +: 16]), 64'(16'd4));
        checkOutput("t6_perf2", 64'(bus.perf_conflict[2*16 +: 16]), 64'(16'd5));
        checkOutput("t6_perf3", 64'(bus.perf_conflict[3*16 +: 16]), 64'(16'd5));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
